spi_flash_reader: RTL

//  SPI master that copies a boot image out of the on-board SPI flash into local memory.

---
 rtl/spi_flash_reader.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/spi_flash_reader.sv
// rtl/spi_flash_reader.sv - SPI boot-image reader assembling 32-bit words onto a write port
module spi_flash_reader #(
    parameter int CLK_DIV = 4,
    parameter int SS_GAP  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] word_count,
    output logic        busy,
    output logic        done,
    output logic        wvalid,
    input  logic        wready,
    output logic [31:0] waddr,
    output logic [31:0] wdata,
    output logic        ss,
    output logic        sck,
    output logic        mosi,
    input  logic        miso
);

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        SHIFT,
        DESELECT,
        WRITE,
        DONE
    } state_t;

    // Terminal values of the shared phase counter for one sck half-period and one ss gap
    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST = 16'(SS_GAP - 1);

    state_t      state;
    logic [15:0] cnt;
    logic [3:0]  half;
    logic [1:0]  byte_idx;
    logic [7:0]  shreg;
    logic [15:0] word_idx;
    logic [15:0] word_total;
    logic [15:0] word_next;

    // The flash ignores mosi; it only needs sck and ss
    assign mosi      = 1'b0;
    assign word_next = word_idx + 16'd1;

    // Transfer sequencer: one ss pulse per byte, four bytes per word, then a write handshake
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 16'd0;
            half       <= 4'd0;
            byte_idx   <= 2'd0;
            shreg      <= 8'd0;
            word_idx   <= 16'd0;
            word_total <= 16'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            wvalid     <= 1'b0;
            waddr      <= 32'd0;
            wdata      <= 32'd0;
            ss         <= 1'b1;
            sck        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy       <= 1'b1;
                        word_total <= word_count;
                        word_idx   <= 16'd0;
                        byte_idx   <= 2'd0;
                        cnt        <= 16'd0;
                        if (word_count == 16'd0) begin
                            state <= DONE;
                        end else begin
                            ss    <= 1'b0;
                            state <= SELECT;
                        end
                    end
                end

                SELECT: begin
                    // ss has been low for one half-period: first rising sck edge, first sample
                    if (cnt == DIV_LAST) begin
                        cnt   <= 16'd0;
                        half  <= 4'd0;
                        sck   <= 1'b1;
                        shreg <= {shreg[6:0], miso};
                        state <= SHIFT;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                SHIFT: begin
                    // Even halves are sck high, odd halves low; half 15 is the final low phase
                    if (cnt == DIV_LAST) begin
                        cnt <= 16'd0;
                        if (half == 4'd15) begin
                            ss                          <= 1'b1;
                            wdata[{byte_idx, 3'b000} +: 8] <= shreg;
                            state                       <= DESELECT;
                        end else begin
                            half <= half + 4'd1;
                            sck  <= ~sck;
                            if (!sck) begin
                                shreg <= {shreg[6:0], miso};
                            end
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                DESELECT: begin
                    if (cnt == GAP_LAST) begin
                        cnt <= 16'd0;
                        if (byte_idx == 2'd3) begin
                            wvalid <= 1'b1;
                            waddr  <= {14'd0, word_idx, 2'b00};
                            state  <= WRITE;
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                            ss       <= 1'b0;
                            state    <= SELECT;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                WRITE: begin
                    // ss stays high and sck low for as long as the sink stalls
                    if (wready) begin
                        wvalid   <= 1'b0;
                        word_idx <= word_next;
                        byte_idx <= 2'd0;
                        if (word_next == word_total) begin
                            state <= DONE;
                        end else begin
                            ss    <= 1'b0;
                            state <= SELECT;
                        end
                    end
                end

                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
